// File: rtl/state_transitions.sv
// Vending-machine order controller: edge-detected buttons and coins drive a one-hot FSM
// with saturating money buffers and an 8-digit multiplexed seven-segment display.
module state_transitions (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       sys_Goods,
    input  logic       sys_Confirm,
    input  logic       sys_Change,
    input  logic       sys_Cancel,
    input  logic       in_money_one,
    input  logic       in_money_five,
    input  logic       in_money_ten,
    input  logic       in_money_twenty,
    input  logic       in_money_fifty,
    input  logic [2:0] type_SW_high,
    input  logic [2:0] type_SW_low,
    input  logic [1:0] num_SW,
    output logic [7:0] Bit_select,
    output logic [7:0] Seg_select,
    output logic [5:0] state_out,
    output logic [7:0] need_money_out,
    output logic [7:0] input_money_out,
    output logic [7:0] change_money_out
);

    typedef enum logic [5:0] {
        ST_IDLE     = 6'b000001,
        ST_SELECT   = 6'b000010,
        ST_PAY      = 6'b000100,
        ST_CHANGE   = 6'b001000,
        ST_DISPENSE = 6'b010000,
        ST_REFUND   = 6'b100000
    } state_t;

    localparam logic [9:0] SCAN_LAST = 10'd999;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    function automatic logic [7:0] seg_code(input logic [7:0] digit, input logic blank);
        logic [7:0] code;
        code = 8'hFF;
        if (blank) begin
            code = 8'hFF;
        end else begin
            case (digit)
                8'd0:    code = 8'hC0;
                8'd1:    code = 8'hF9;
                8'd2:    code = 8'hA4;
                8'd3:    code = 8'hB0;
                8'd4:    code = 8'h99;
                8'd5:    code = 8'h92;
                8'd6:    code = 8'h82;
                8'd7:    code = 8'hF8;
                8'd8:    code = 8'h80;
                8'd9:    code = 8'h90;
                default: code = 8'hFF;
            endcase
        end
        return code;
    endfunction

    // Place 0 is the thousands digit (always blank for an 8-bit value), place 3 the ones.
    function automatic logic [7:0] digit_seg(input logic [7:0] value, input logic [1:0] place);
        logic [7:0] seg;
        case (place)
            2'd0:    seg = seg_code(8'd0, 1'b1);
            2'd1:    seg = seg_code(value / 8'd100, value < 8'd100);
            2'd2:    seg = seg_code((value / 8'd10) % 8'd10, value < 8'd10);
            2'd3:    seg = seg_code(value % 8'd10, 1'b0);
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] need_q, need_d;
    logic [7:0] input_q, input_d;
    logic [7:0] change_q, change_d;
    logic [8:0] btn_s, btn_q, btn_prev_q, edge_s;
    logic       cancel_e_s, confirm_e_s, goods_e_s, change_e_s;
    logic [7:0] money_s, cost_s, inp_sum_s;
    logic [3:0] unit_s;
    logic [9:0] scan_q;
    logic [2:0] digit_q;
    logic [7:0] bit_sel_q, bit_sel_d, seg_sel_q, seg_sel_d;
    logic [7:0] right_val_s, disp_val_s;

    assign btn_s = {sys_Cancel, sys_Confirm, sys_Goods, sys_Change, in_money_fifty,
                    in_money_twenty, in_money_ten, in_money_five, in_money_one};
    assign edge_s      = btn_q & ~btn_prev_q;
    assign cancel_e_s  = edge_s[8];
    assign confirm_e_s = edge_s[7];
    assign goods_e_s   = edge_s[6];
    assign change_e_s  = edge_s[5];

    assign unit_s    = {1'b0, type_SW_high} + {1'b0, type_SW_low};
    assign cost_s    = {4'b0000, unit_s} * {6'b000000, num_SW};
    assign money_s   = (edge_s[0] ? 8'd1  : 8'd0) + (edge_s[1] ? 8'd5  : 8'd0)
                     + (edge_s[2] ? 8'd10 : 8'd0) + (edge_s[3] ? 8'd20 : 8'd0)
                     + (edge_s[4] ? 8'd50 : 8'd0);
    assign inp_sum_s = sat_add(input_q, money_s);

    // Input sampling register and its delayed copy for rising-edge detection.
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            btn_q      <= 9'd0;
            btn_prev_q <= 9'd0;
        end else begin
            btn_q      <= btn_s;
            btn_prev_q <= btn_q;
        end
    end

    // FSM state and money buffer registers.
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            state_q  <= ST_IDLE;
            need_q   <= 8'd0;
            input_q  <= 8'd0;
            change_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            need_q   <= need_d;
            input_q  <= input_d;
            change_q <= change_d;
        end
    end

    // Next-state and buffer update logic; button priority Cancel > Confirm > Goods > Change.
    always_comb begin
        state_d  = state_q;
        need_d   = need_q;
        input_d  = input_q;
        change_d = change_q;
        case (state_q)
            ST_IDLE: begin
                if (confirm_e_s) begin
                    state_d = ST_SELECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SELECT: begin
                if (cancel_e_s) begin
                    state_d  = ST_REFUND;
                    change_d = input_q;
                    need_d   = 8'd0;
                end else if (confirm_e_s) begin
                    need_d  = sat_add(need_q, cost_s);
                    state_d = ST_PAY;
                end else if (goods_e_s) begin
                    need_d = sat_add(need_q, cost_s);
                end else begin
                    state_d = ST_SELECT;
                end
            end
            ST_PAY: begin
                if (cancel_e_s) begin
                    state_d  = ST_REFUND;
                    change_d = input_q;
                    need_d   = 8'd0;
                end else begin
                    input_d = inp_sum_s;
                    if (inp_sum_s >= need_q) begin
                        state_d  = ST_CHANGE;
                        change_d = inp_sum_s - need_q;
                    end else begin
                        state_d = ST_PAY;
                    end
                end
            end
            ST_CHANGE: begin
                if (change_e_s) begin
                    state_d = ST_DISPENSE;
                end else begin
                    state_d = ST_CHANGE;
                end
            end
            ST_DISPENSE, ST_REFUND: begin
                if (change_e_s) begin
                    state_d  = ST_IDLE;
                    need_d   = 8'd0;
                    input_d  = 8'd0;
                    change_d = 8'd0;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                need_d   = 8'd0;
                input_d  = 8'd0;
                change_d = 8'd0;
            end
        endcase
    end

    // Digit scan timer: one digit per 1000 clocks, leftmost digit first.
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            scan_q  <= 10'd0;
            digit_q <= 3'd0;
        end else if (scan_q == SCAN_LAST) begin
            scan_q  <= 10'd0;
            digit_q <= digit_q + 3'd1;
        end else begin
            scan_q <= scan_q + 10'd1;
        end
    end

    // Right half shows paid money until payment completes, then the change owed.
    always_comb begin
        right_val_s = change_q;
        if ((state_q == ST_IDLE) || (state_q == ST_SELECT) || (state_q == ST_PAY)) begin
            right_val_s = input_q;
        end else begin
            right_val_s = change_q;
        end
        disp_val_s = digit_q[2] ? right_val_s : need_q;
        bit_sel_d  = ~(8'b1000_0000 >> digit_q);
        seg_sel_d  = digit_seg(disp_val_s, digit_q[1:0]);
    end

    // Registered display drivers.
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            bit_sel_q <= 8'b0111_1111;
            seg_sel_q <= 8'hFF;
        end else begin
            bit_sel_q <= bit_sel_d;
            seg_sel_q <= seg_sel_d;
        end
    end

    assign Bit_select       = bit_sel_q;
    assign Seg_select       = seg_sel_q;
    assign state_out        = state_q;
    assign need_money_out   = need_q;
    assign input_money_out  = input_q;
    assign change_money_out = change_q;

endmodule

// File: tb/tb_state_transitions.sv
// Scoreboard bench for state_transitions: a transaction-level vending model predicts state,
// buffers and display; a negedge monitor pops expectations and compares against the DUT.
module tb_state_transitions;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b1;
    logic       sys_Goods = 1'b0, sys_Confirm = 1'b0, sys_Change = 1'b0, sys_Cancel = 1'b0;
    logic       in_money_one = 1'b0, in_money_five = 1'b0, in_money_ten = 1'b0;
    logic       in_money_twenty = 1'b0, in_money_fifty = 1'b0;
    logic [2:0] type_SW_high = 3'd0, type_SW_low = 3'd0;
    logic [1:0] num_SW = 2'd0;
    logic [7:0] Bit_select, Seg_select, need_money_out, input_money_out, change_money_out;
    logic [5:0] state_out;

    state_transitions dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sys_Goods(sys_Goods),
        .sys_Confirm(sys_Confirm), .sys_Change(sys_Change), .sys_Cancel(sys_Cancel),
        .in_money_one(in_money_one), .in_money_five(in_money_five), .in_money_ten(in_money_ten),
        .in_money_twenty(in_money_twenty), .in_money_fifty(in_money_fifty),
        .type_SW_high(type_SW_high), .type_SW_low(type_SW_low), .num_SW(num_SW),
        .Bit_select(Bit_select), .Seg_select(Seg_select), .state_out(state_out),
        .need_money_out(need_money_out), .input_money_out(input_money_out),
        .change_money_out(change_money_out)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int         kind;   // 0: state/buffers, 1: display digit
        string      name;
        logic [5:0] st;
        logic [7:0] nd, inp, chg, bs, ss;
        int         ivl;    // >=0 exact scan interval, -1 scan merely seen, -2 not checked
        int         act_ivl;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    localparam int M_IDLE = 0, M_SELECT = 1, M_PAY = 2, M_CHANGE = 3, M_DISPENSE = 4, M_REFUND = 5;
    int m_st = M_IDLE, m_need = 0, m_inp = 0, m_chg = 0;
    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic int sat255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: one queued expectation compared per falling edge.
    always @(negedge sys_clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.kind == 0) begin
                chk({e.name, ".state"},  int'(state_out),        int'(e.st));
                chk({e.name, ".need"},   int'(need_money_out),   int'(e.nd));
                chk({e.name, ".input"},  int'(input_money_out),  int'(e.inp));
                chk({e.name, ".change"}, int'(change_money_out), int'(e.chg));
            end else begin
                chk({e.name, ".bit"}, int'(Bit_select), int'(e.bs));
                chk({e.name, ".seg"}, int'(Seg_select), int'(e.ss));
                if (e.ivl >= 0) chk({e.name, ".interval"}, e.act_ivl, e.ivl);
                else if (e.ivl == -1) chk({e.name, ".scan_seen"}, int'(e.act_ivl < 1200), 1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_need = 0; m_inp = 0; m_chg = 0;
    endtask

    // Order rules at transaction level: one call per simultaneous group of button/coin edges.
    task automatic model_step(input bit c_cancel, input bit c_confirm, input bit c_goods,
                              input bit c_change, input bit [4:0] mon, input int hi, input int lo,
                              input int num);
        int cost, cash;
        cost = (hi + lo) * num;
        cash = (mon[0] ? 1 : 0) + (mon[1] ? 5 : 0) + (mon[2] ? 10 : 0)
             + (mon[3] ? 20 : 0) + (mon[4] ? 50 : 0);
        case (m_st)
            M_IDLE:   if (c_confirm) m_st = M_SELECT;
            M_SELECT: begin
                if (c_cancel) begin m_st = M_REFUND; m_chg = m_inp; m_need = 0; end
                else if (c_confirm) begin m_need = sat255(m_need + cost); m_st = M_PAY; end
                else if (c_goods) m_need = sat255(m_need + cost);
            end
            M_PAY: begin
                if (c_cancel) begin m_st = M_REFUND; m_chg = m_inp; m_need = 0; end
                else m_inp = sat255(m_inp + cash);
            end
            M_CHANGE: if (c_change) m_st = M_DISPENSE;
            default:  if (c_change) model_reset();
        endcase
        if (m_st == M_PAY && m_inp >= m_need) begin
            m_st = M_CHANGE;
            m_chg = m_inp - m_need;
        end
    endtask

    task automatic push_state(input string nm);
        exp_t e;
        e.kind = 0; e.name = nm; e.st = 6'(1 << m_st);
        e.nd = 8'(m_need); e.inp = 8'(m_inp); e.chg = 8'(m_chg);
        e.bs = 8'd0; e.ss = 8'd0; e.ivl = -2; e.act_ivl = 0;
        sbq.push_back(e);
    endtask

    function automatic logic [7:0] model_seg(input int p);
        int    v;
        string s;
        byte   ch;
        if (p < 4) v = m_need;
        else if (m_st == M_IDLE || m_st == M_SELECT || m_st == M_PAY) v = m_inp;
        else v = m_chg;
        s = $sformatf("%4d", v);
        ch = s[p % 4];
        return (ch == " ") ? 8'hFF : seg_tab[ch - "0"];
    endfunction

    task automatic push_disp(input string nm, input logic [7:0] bs, input logic [7:0] ss,
                             input int ivl, input int act_ivl);
        exp_t e;
        e.kind = 1; e.name = nm; e.st = 6'd0; e.nd = 8'd0; e.inp = 8'd0; e.chg = 8'd0;
        e.bs = bs; e.ss = ss; e.ivl = ivl; e.act_ivl = act_ivl;
        sbq.push_back(e);
    endtask

    task automatic press(input string nm, input bit c_cancel, input bit c_confirm,
                         input bit c_goods, input bit c_change, input bit [4:0] mon,
                         input int hi, input int lo, input int num);
        type_SW_high = 3'(hi); type_SW_low = 3'(lo); num_SW = 2'(num);
        sys_Cancel = c_cancel; sys_Confirm = c_confirm; sys_Goods = c_goods; sys_Change = c_change;
        {in_money_fifty, in_money_twenty, in_money_ten, in_money_five, in_money_one} = mon;
        tick(1);
        sys_Cancel = 1'b0; sys_Confirm = 1'b0; sys_Goods = 1'b0; sys_Change = 1'b0;
        {in_money_fifty, in_money_twenty, in_money_ten, in_money_five, in_money_one} = 5'd0;
        tick(3);
        model_step(c_cancel, c_confirm, c_goods, c_change, mon, hi, lo, num);
        push_state(nm);
    endtask

    task automatic wait_bs(output int cyc);
        logic [7:0] old;
        old = Bit_select;
        cyc = 0;
        while (Bit_select == old && cyc < 1200) begin
            tick(1);
            cyc++;
        end
    endtask

    initial begin
        int cyc, k0, p;
        bit c_cancel, c_confirm, c_goods, c_change;
        bit [4:0] mon;

        tick(3);
        model_reset();
        push_state("reset");
        push_disp("reset_disp", 8'b0111_1111, 8'hFF, -2, 0);
        tick(2);
        sys_rst_n = 1'b0;
        tick(2);

        press("idle_ignore", 1, 0, 1, 1, 5'b11111, 7, 7, 3);
        press("idle_confirm", 0, 1, 0, 0, 5'd0, 0, 0, 0);
        press("goods_2_1_3", 0, 0, 1, 0, 5'd0, 2, 1, 3);
        press("confirm_3_3_1", 0, 1, 0, 0, 5'd0, 3, 3, 1);
        press("pay_one", 0, 0, 0, 0, 5'b00001, 0, 0, 0);
        press("pay_five", 0, 0, 0, 0, 5'b00010, 0, 0, 0);
        press("pay_ten", 0, 0, 0, 0, 5'b00100, 0, 0, 0);
        press("change_twenty", 0, 0, 0, 0, 5'b01000, 0, 0, 0);
        press("change_fifty", 0, 0, 0, 0, 5'b10000, 0, 0, 0);
        press("to_dispense", 0, 0, 0, 1, 5'd0, 0, 0, 0);
        press("to_idle", 0, 0, 0, 1, 5'd0, 0, 0, 0);
        press("idle_change", 0, 0, 0, 1, 5'd0, 0, 0, 0);

        press("r_confirm", 0, 1, 0, 0, 5'd0, 0, 0, 0);
        press("r_need15", 0, 1, 0, 0, 5'd0, 3, 2, 3);
        press("r_one", 0, 0, 0, 0, 5'b00001, 0, 0, 0);
        press("r_five", 0, 0, 0, 0, 5'b00010, 0, 0, 0);
        press("r_cancel", 1, 0, 0, 0, 5'd0, 0, 0, 0);
        press("r_change", 0, 0, 0, 1, 5'd0, 0, 0, 0);

        // A level held for several cycles must add only once.
        press("h_confirm", 0, 1, 0, 0, 5'd0, 0, 0, 0);
        type_SW_high = 3'd1; type_SW_low = 3'd1; num_SW = 2'd1; sys_Goods = 1'b1;
        tick(6);
        sys_Goods = 1'b0;
        tick(3);
        model_step(0, 0, 1, 0, 5'd0, 1, 1, 1);
        push_state("held_goods");
        press("prio_cancel", 1, 1, 1, 0, 5'd0, 3, 3, 3);
        press("prio_exit", 0, 0, 0, 1, 5'd0, 0, 0, 0);
        press("p_confirm", 0, 1, 0, 0, 5'd0, 0, 0, 0);
        press("prio_confirm", 0, 1, 1, 0, 5'd0, 1, 2, 2);
        press("money_sum", 0, 0, 0, 0, 5'b00011, 0, 0, 0);
        press("p_chg1", 0, 0, 0, 1, 5'd0, 0, 0, 0);
        press("p_chg2", 0, 0, 0, 1, 5'd0, 0, 0, 0);

        press("s_confirm", 0, 1, 0, 0, 5'd0, 0, 0, 0);
        for (int i = 0; i < 7; i++) press("sat_need", 0, 0, 1, 0, 5'd0, 7, 7, 3);
        press("s_pay", 0, 1, 0, 0, 5'd0, 0, 0, 0);
        for (int i = 0; i < 6; i++) press("sat_input", 0, 0, 0, 0, 5'b10000, 0, 0, 0);
        press("s_chg1", 0, 0, 0, 1, 5'd0, 0, 0, 0);
        press("s_chg2", 0, 0, 0, 1, 5'd0, 0, 0, 0);

        press("z_confirm", 0, 1, 0, 0, 5'd0, 0, 0, 0);
        press("zero_need", 0, 1, 0, 0, 5'd0, 5, 5, 0);
        press("z_chg1", 0, 0, 0, 1, 5'd0, 0, 0, 0);
        press("z_chg2", 0, 0, 0, 1, 5'd0, 0, 0, 0);

        press("a_confirm", 0, 1, 0, 0, 5'd0, 0, 0, 0);
        press("a_need15", 0, 1, 0, 0, 5'd0, 3, 2, 3);
        press("a_five", 0, 0, 0, 0, 5'b00010, 0, 0, 0);
        @(posedge sys_clk);
        #3 sys_rst_n = 1'b1;
        #1;
        model_reset();
        push_state("async_reset");
        tick(3);
        sys_rst_n = 1'b0;
        tick(2);

        press("d_confirm", 0, 1, 0, 0, 5'd0, 0, 0, 0);
        press("d_need15", 0, 1, 0, 0, 5'd0, 3, 2, 3);
        press("d_five", 0, 0, 0, 0, 5'b00010, 0, 0, 0);
        press("d_one", 0, 0, 0, 0, 5'b00001, 0, 0, 0);
        wait_bs(cyc);
        k0 = 0;
        for (int q = 0; q < 8; q++) if (Bit_select == ~(8'h80 >> q)) k0 = q;
        push_disp("disp_first", ~(8'h80 >> k0), model_seg(k0), -1, cyc);
        tick(1);
        for (int i = 1; i <= 8; i++) begin
            wait_bs(cyc);
            p = (k0 + i) % 8;
            push_disp($sformatf("disp_pos%0d", p), ~(8'h80 >> p), model_seg(p), 1000, cyc + 1);
            tick(1);
        end

        for (int i = 0; i < 200; i++) begin
            c_cancel = 0; c_confirm = 0; c_goods = 0; c_change = 0;
            mon = 5'($urandom) & 5'($urandom);
            if (m_st == M_IDLE) begin
                c_confirm = 1'($urandom_range(0, 1));
                c_cancel  = 1'($urandom_range(0, 1));
                c_goods   = 1'($urandom_range(0, 1));
            end else if (m_st == M_SELECT || m_st == M_PAY) begin
                c_cancel  = ($urandom_range(0, 9) == 0);
                c_confirm = ($urandom_range(0, 3) == 0);
                c_goods   = ($urandom_range(0, 2) == 0);
                c_change  = 1'($urandom_range(0, 1));
            end else begin
                c_change  = 1'($urandom_range(0, 1));
            end
            press($sformatf("rand%0d", i), c_cancel, c_confirm, c_goods, c_change, mon,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 20 && sbq.size() > 0; i++) tick(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
